// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: captures the departing memory-stage instruction, selects the writeback
// value and drives the register-file write port one cycle later; also owns the sticky halt flag and retire counter.
module mem_wb_stage #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 valid_in,
  input  logic                 reg_write_in,
  input  logic [3:0]           dst_reg_in,
  input  logic [1:0]           wb_sel_in,
  input  logic                 halt_in,
  input  logic [WIDTH-1:0]     alu_result_in,
  input  logic [WIDTH-1:0]     mem_data_in,
  input  logic [WIDTH-1:0]     pc_plus2_in,
  output logic                 WriteReg,
  output logic [3:0]           DstReg,
  output logic [WIDTH-1:0]     DstData,
  output logic                 valid_out,
  output logic                 halt,
  output logic [CNT_WIDTH-1:0] retired_count
);

  logic                 valid_q, valid_d;
  logic                 reg_write_q, reg_write_d;
  logic [3:0]           dst_reg_q, dst_reg_d;
  logic [1:0]           wb_sel_q, wb_sel_d;
  logic                 halt_q, halt_d;
  logic [WIDTH-1:0]     alu_q, alu_d;
  logic [WIDTH-1:0]     mem_q, mem_d;
  logic [WIDTH-1:0]     pc2_q, pc2_d;
  logic                 halted_q, halted_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 depart;
  logic                 hlt_depart;

  always_comb begin
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    dst_reg_d   = dst_reg_q;
    wb_sel_d    = wb_sel_q;
    halt_d      = halt_q;
    alu_d       = alu_q;
    mem_d       = mem_q;
    pc2_d       = pc2_q;
    halted_d    = halted_q;
    cnt_d       = cnt_q;

    // An instruction departs (and is counted) whenever it is not held, even if flushed.
    depart     = valid_q & ~stall & ~halted_q;
    hlt_depart = depart & halt_q;

    if (depart && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    if (halted_q) begin
      valid_d = 1'b0;
    end else begin
      if (flush) begin
        valid_d = 1'b0;
      end else if (!stall) begin
        valid_d     = valid_in;
        reg_write_d = reg_write_in;
        dst_reg_d   = dst_reg_in;
        wb_sel_d    = wb_sel_in;
        halt_d      = halt_in;
        alu_d       = alu_result_in;
        mem_d       = mem_data_in;
        pc2_d       = pc_plus2_in;
      end
      if (hlt_depart) begin
        halted_d = 1'b1;
        valid_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      dst_reg_q   <= '0;
      wb_sel_q    <= '0;
      halt_q      <= 1'b0;
      alu_q       <= '0;
      mem_q       <= '0;
      pc2_q       <= '0;
      halted_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      dst_reg_q   <= dst_reg_d;
      wb_sel_q    <= wb_sel_d;
      halt_q      <= halt_d;
      alu_q       <= alu_d;
      mem_q       <= mem_d;
      pc2_q       <= pc2_d;
      halted_q    <= halted_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    case (wb_sel_q)
      2'b01:   DstData = mem_q;
      2'b10:   DstData = pc2_q;
      default: DstData = alu_q;
    endcase
  end

  // An HLT never writes, even if it was decoded with reg_write set.
  assign WriteReg      = valid_q & reg_write_q & (dst_reg_q != 4'd0) & ~halt_q & ~halted_q;
  assign DstReg        = dst_reg_q;
  assign valid_out     = valid_q & ~halted_q;
  assign halt          = halted_q;
  assign retired_count = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized + directed bench for mem_wb_stage with an entry-level reference model and a scoreboard queue.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst, stall, flush, valid_in, reg_write_in, halt_in;
  logic [3:0]  dst_reg_in;
  logic [1:0]  wb_sel_in;
  logic [15:0] alu_result_in, mem_data_in, pc_plus2_in;

  logic        WriteReg, valid_out, halt;
  logic [3:0]  DstReg;
  logic [15:0] DstData, retired_count;

  logic        WriteReg4, valid_out4, halt4;
  logic [3:0]  DstReg4;
  logic [15:0] DstData4;
  logic [3:0]  retired_count4;

  mem_wb_stage #(.WIDTH(16), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .reg_write_in(reg_write_in), .dst_reg_in(dst_reg_in), .wb_sel_in(wb_sel_in),
    .halt_in(halt_in), .alu_result_in(alu_result_in), .mem_data_in(mem_data_in),
    .pc_plus2_in(pc_plus2_in), .WriteReg(WriteReg), .DstReg(DstReg), .DstData(DstData),
    .valid_out(valid_out), .halt(halt), .retired_count(retired_count)
  );

  mem_wb_stage #(.WIDTH(16), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .reg_write_in(reg_write_in), .dst_reg_in(dst_reg_in), .wb_sel_in(wb_sel_in),
    .halt_in(halt_in), .alu_result_in(alu_result_in), .mem_data_in(mem_data_in),
    .pc_plus2_in(pc_plus2_in), .WriteReg(WriteReg4), .DstReg(DstReg4), .DstData(DstData4),
    .valid_out(valid_out4), .halt(halt4), .retired_count(retired_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one WB slot holding the already-selected writeback value.
  typedef struct packed {
    logic        v;
    logic        we;
    logic        hlt;
    logic [3:0]  dst;
    logic [15:0] dat;
  } slot_t;

  typedef struct packed {
    logic        vo;
    logic        wr;
    logic        hlt;
    logic        chk_dat;
    logic [3:0]  dst;
    logic [15:0] dat;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  slot_t m_slot;
  bit    m_halted;
  int    m_cnt, m_cnt4;
  exp_t  exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic model_edge();
    exp_t  e;
    bit    hlt_leaves;
    logic [15:0] sel_val;
    hlt_leaves = 0;
    if (rst) begin
      m_slot   = '0;
      m_halted = 0;
      m_cnt    = 0;
      m_cnt4   = 0;
    end else if (!m_halted) begin
      if (m_slot.v && !stall) begin
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        if (m_cnt4 < 15) m_cnt4 = m_cnt4 + 1;
        hlt_leaves = m_slot.hlt;
      end
      if (flush) m_slot.v = 1'b0;
      else if (!stall) begin
        case (wb_sel_in)
          2'b01:   sel_val = mem_data_in;
          2'b10:   sel_val = pc_plus2_in;
          default: sel_val = alu_result_in;
        endcase
        m_slot = '{v: valid_in, we: reg_write_in, hlt: halt_in, dst: dst_reg_in, dat: sel_val};
      end
      if (hlt_leaves) m_halted = 1;
    end
    e.vo      = m_slot.v && !m_halted;
    e.wr      = m_slot.v && m_slot.we && (m_slot.dst != 0) && !m_slot.hlt && !m_halted;
    e.hlt     = m_halted;
    e.chk_dat = e.wr || rst;
    e.dst     = m_slot.dst;
    e.dat     = m_slot.dat;
    e.cnt     = 16'(m_cnt);
    e.cnt4    = 4'(m_cnt4);
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit r, input bit s, input bit f, input bit v, input bit we,
                       input bit [3:0] d, input bit [1:0] sel, input bit h,
                       input bit [15:0] a, input bit [15:0] m, input bit [15:0] p);
    @(negedge clk);
    rst = r; stall = s; flush = f; valid_in = v; reg_write_in = we;
    dst_reg_in = d; wb_sel_in = sel; halt_in = h;
    alu_result_in = a; mem_data_in = m; pc_plus2_in = p;
    model_edge();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 4'd0, 2'd0, 0, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Monitor: one expected record per clock edge, compared just after that edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("valid_out", {31'd0, valid_out}, {31'd0, e.vo});
        chk("WriteReg", {31'd0, WriteReg}, {31'd0, e.wr});
        chk("halt", {31'd0, halt}, {31'd0, e.hlt});
        chk("retired_count", {16'd0, retired_count}, {16'd0, e.cnt});
        chk("retired_count4", {28'd0, retired_count4}, {28'd0, e.cnt4});
        chk("WriteReg4", {31'd0, WriteReg4}, {31'd0, e.wr});
        chk("valid_out4", {31'd0, valid_out4}, {31'd0, e.vo});
        chk("halt4", {31'd0, halt4}, {31'd0, e.hlt});
        if (e.chk_dat) begin
          chk("DstReg", {28'd0, DstReg}, {28'd0, e.dst});
          chk("DstData", {16'd0, DstData}, {16'd0, e.dat});
          chk("DstData4", {16'd0, DstData4}, {16'd0, e.dat});
          chk("DstReg4", {28'd0, DstReg4}, {28'd0, e.dst});
        end
      end
    end
  end

  initial begin
    rst = 1; stall = 0; flush = 0; valid_in = 0; reg_write_in = 0; halt_in = 0;
    dst_reg_in = 0; wb_sel_in = 0; alu_result_in = 0; mem_data_in = 0; pc_plus2_in = 0;

    drive(1, 0, 0, 0, 0, 4'd0, 2'd0, 0, 16'h0, 16'h0, 16'h0);
    drive(1, 0, 0, 0, 0, 4'd0, 2'd0, 0, 16'h0, 16'h0, 16'h0);
    // ALU writeback, then each writeback source to R5
    drive(0, 0, 0, 1, 1, 4'd3, 2'b00, 0, 16'h1234, 16'h1111, 16'h2222);
    drive(0, 0, 0, 1, 1, 4'd5, 2'b01, 0, 16'h3333, 16'hBEEF, 16'h4444);
    drive(0, 0, 0, 1, 1, 4'd5, 2'b10, 0, 16'h5555, 16'h6666, 16'h0042);
    drive(0, 0, 0, 1, 1, 4'd5, 2'b11, 0, 16'h0007, 16'h7777, 16'h8888);
    // R0 write is suppressed but still retires
    drive(0, 0, 0, 1, 1, 4'd0, 2'b00, 0, 16'hFFFF, 16'h0, 16'h0);
    // Stall holds a pending write for three cycles while inputs churn
    drive(0, 0, 0, 1, 1, 4'd2, 2'b00, 0, 16'h00AA, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++)
      drive(0, 1, 0, 1, 1, 4'($urandom_range(1, 15)), 2'($urandom), 0,
            16'($urandom), 16'($urandom), 16'($urandom));
    idle(1);
    // Flush beats stall
    drive(0, 0, 0, 1, 1, 4'd6, 2'b00, 0, 16'h0C0C, 16'h0, 16'h0);
    drive(0, 1, 1, 1, 1, 4'd7, 2'b00, 0, 16'h0D0D, 16'h0, 16'h0);
    idle(1);
    // HLT with reg_write set, followed by writes that must be ignored
    drive(0, 0, 0, 1, 1, 4'd4, 2'b00, 1, 16'h4444, 16'h0, 16'h0);
    for (int i = 0; i < 4; i++)
      drive(0, 0, 0, 1, 1, 4'(i + 8), 2'b00, 0, 16'($urandom), 16'h0, 16'h0);
    drive(1, 0, 0, 0, 0, 4'd0, 2'd0, 0, 16'h0, 16'h0, 16'h0);
    idle(1);

    // Randomized traffic with occasional HLT and reset
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom % 100) == 0, ($urandom % 4) == 0, ($urandom % 8) == 0,
            ($urandom % 4) != 0, 1'($urandom), 4'($urandom), 2'($urandom),
            ($urandom % 50) == 0, 16'($urandom), 16'($urandom), 16'($urandom));
    end
    // Long clean run so the 4-bit counter reaches and holds saturation
    drive(1, 0, 0, 0, 0, 4'd0, 2'd0, 0, 16'h0, 16'h0, 16'h0);
    for (int i = 0; i < 20; i++)
      drive(0, 0, 0, 1, 1, 4'(i % 16), 2'($urandom), 0, 16'($urandom), 16'($urandom), 16'($urandom));
    idle(2);

    @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
